// File: rtl/uart_cmd_framer_pkg.sv
// Shared definitions for the UART command framer: frame delimiters, FSM encoding,
// command codes and the packed command word carried through the queue.
package uart_cmd_framer_pkg;

  localparam logic [7:0] SOF_BYTE    = 8'h6E;
  localparam logic [7:0] EOF_BYTE    = 8'h6F;
  localparam int         FRAME_BYTES = 5;
  localparam int         WORD_W      = 24;

  // Byte states are numbered so that the state value indexes the byte on the wire.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_CMD  = 3'd2;
  localparam logic [2:0] ST_ARG0 = 3'd3;
  localparam logic [2:0] ST_ARG1 = 3'd4;
  localparam logic [2:0] ST_EOF  = 3'd5;
  localparam logic [2:0] ST_GAP  = 3'd6;

  typedef enum logic [7:0] {
    CMD_RESET         = 8'h00,
    CMD_ASK_VALUE     = 8'h01,
    CMD_ASK_MUX       = 8'h02,
    CMD_OFFSET_VALUE  = 8'h03,
    CMD_CAL_OFFSET    = 8'h04,
    CMD_OFFSET_MUX    = 8'h05,
    CMD_FILTER_MUX    = 8'h06,
    CMD_UPTHRESHOLD   = 8'h07,
    CMD_DOWNTHRESHOLD = 8'h08,
    CMD_CAPTURE_MUX   = 8'h09,
    CMD_CAPTURE_FIRE  = 8'h0A
  } cmd_code_e;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] arg0;
    logic [7:0] arg1;
  } cmd_word_t;

endpackage

// File: rtl/cmd_frame_fifo.sv
// Synchronous command queue with a registered head word. An entry becomes visible
// at the head one cycle after it is written, so the storage maps onto block RAM.
module cmd_frame_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic             empty
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  head_data_reg;
  logic              head_valid_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              push_ok;
  logic              pop_ok;

  assign full       = (count_reg == (ADDR_W+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push_ok    = push && !full;
  assign pop_ok     = pop && head_valid_reg;
  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;

  assign rd_ptr_next = rd_ptr_reg + ADDR_W'(pop_ok);
  assign count_next  = count_reg + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);

  // Storage and registered read port kept free of reset for RAM inference.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
    head_data_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_reg + ADDR_W'(push_ok);
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      // Only entries already written before this edge are readable next cycle.
      head_valid_reg <= (count_reg != (ADDR_W+1)'(pop_ok));
    end
  end

endmodule

// File: rtl/uart_cmd_framer.sv
// Turns queued {cmd, arg0, arg1} words into 5-byte frames (6E cmd arg0 arg1 6F)
// on a registered valid/ready byte stream, with optional idle gap between frames.
module uart_cmd_framer
  import uart_cmd_framer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         i_cmd,
  input  logic [7:0]         i_arg0,
  input  logic [7:0]         i_arg1,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [7:0]         o_tdata,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic               busy,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  cmd_word_t          push_word;
  logic [WORD_W-1:0]  head_data;
  logic               head_valid;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  logic [2:0]         state_reg, state_next;
  logic [WORD_W-1:0]  frame_reg, frame_next;
  logic               o_tvalid_reg, o_tvalid_next;
  logic [7:0]         o_tdata_reg, o_tdata_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic               byte_done;
  logic [7:0]         frame_byte [FRAME_BYTES];

  assign push_word = '{cmd: i_cmd, arg0: i_arg0, arg1: i_arg1};

  cmd_frame_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (i_tvalid),
    .push_data  (push_word),
    .pop        (fifo_pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Byte n of the frame lives at frame_byte[n]; payload comes from the frame register.
  assign frame_byte[0]             = SOF_BYTE;
  assign frame_byte[FRAME_BYTES-1] = EOF_BYTE;
  for (genvar gi = 0; gi < 3; gi++) begin : g_payload
    assign frame_byte[gi+1] = frame_reg[WORD_W-1-8*gi -: 8];
  end

  assign byte_done   = o_tvalid_reg && o_tready;
  assign i_tready    = !fifo_full;
  assign o_tvalid    = o_tvalid_reg;
  assign o_tdata     = o_tdata_reg;
  assign frame_count = count_reg;
  assign busy        = (state_reg != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_next    = state_reg;
    frame_next    = frame_reg;
    o_tvalid_next = o_tvalid_reg;
    o_tdata_next  = o_tdata_reg;
    count_next    = count_reg;
    gap_next      = gap_reg;
    fifo_pop      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (head_valid) begin
          fifo_pop      = 1'b1;
          frame_next    = head_data;
          state_next    = ST_SOF;
          o_tvalid_next = 1'b1;
          o_tdata_next  = frame_byte[0];
        end
      end
      ST_SOF, ST_CMD, ST_ARG0, ST_ARG1: begin
        if (byte_done) begin
          state_next   = state_reg + 3'd1;
          o_tdata_next = frame_byte[state_reg];
        end
      end
      ST_EOF: begin
        if (byte_done) begin
          o_tvalid_next = 1'b0;
          count_next    = count_reg + COUNT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_next = ST_GAP;
            gap_next   = GAP_W'(GAP_LOAD_I);
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      frame_reg    <= '0;
      o_tvalid_reg <= 1'b0;
      o_tdata_reg  <= 8'h00;
      count_reg    <= '0;
      gap_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      frame_reg    <= frame_next;
      o_tvalid_reg <= o_tvalid_next;
      o_tdata_reg  <= o_tdata_next;
      count_reg    <= count_next;
      gap_reg      <= gap_next;
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed and randomized bench for uart_cmd_framer; two instances cover the
// no-gap/16-bit-count and 3-cycle-gap/4-bit-count configurations.
module tb_uart_cmd_framer;

  typedef logic [7:0] byte_q_t [$];

  logic        clk = 1'b0;
  logic        rst_s  [2];
  logic [7:0]  cmd_s  [2];
  logic [7:0]  a0_s   [2];
  logic [7:0]  a1_s   [2];
  logic        iv     [2];
  logic        ir     [2];
  logic [7:0]  od     [2];
  logic        ov     [2];
  logic        ordy   [2];
  logic        busy_s [2];
  logic [15:0] fc0;
  logic [3:0]  fc1;

  int          checks   = 0;
  int          failures = 0;
  int          rdy_mode [2];
  byte_q_t     exp_q    [2];
  int          pos         [2];
  int          frames_done [2];
  logic        stall_prev  [2];
  logic [7:0]  hold_data   [2];

  always #5 clk = ~clk;

  uart_cmd_framer #(.DEPTH(4), .GAP_CYCLES(0), .COUNT_W(16)) dut0 (
    .clk(clk), .rst(rst_s[0]), .i_cmd(cmd_s[0]), .i_arg0(a0_s[0]), .i_arg1(a1_s[0]),
    .i_tvalid(iv[0]), .i_tready(ir[0]), .o_tdata(od[0]), .o_tvalid(ov[0]),
    .o_tready(ordy[0]), .busy(busy_s[0]), .frame_count(fc0)
  );

  uart_cmd_framer #(.DEPTH(4), .GAP_CYCLES(3), .COUNT_W(4)) dut1 (
    .clk(clk), .rst(rst_s[1]), .i_cmd(cmd_s[1]), .i_arg0(a0_s[1]), .i_arg1(a1_s[1]),
    .i_tvalid(iv[1]), .i_tready(ir[1]), .o_tdata(od[1]), .o_tvalid(ov[1]),
    .o_tready(ordy[1]), .busy(busy_s[1]), .frame_count(fc1)
  );

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [7:0] rand_arg();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 8'h6E;
    if (r == 1) return 8'h6F;
    return 8'($urandom);
  endfunction

  // Reference: each accepted command contributes exactly five bytes in order.
  task automatic model_add(input int d, input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1);
    exp_q[d].push_back(8'h6E);
    exp_q[d].push_back(c);
    exp_q[d].push_back(a0);
    exp_q[d].push_back(a1);
    exp_q[d].push_back(8'h6F);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rdy_mode[d])
        1:       ordy[d] = ~ordy[d];
        2:       ordy[d] = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  endtask

  task automatic push(input int d, input logic [7:0] c, input logic [7:0] a0, input logic [7:0] a1);
    logic acc;
    int   waited;
    cmd_s[d] = c; a0_s[d] = a0; a1_s[d] = a1; iv[d] = 1'b1;
    acc = 1'b0; waited = 0;
    while (!acc && waited < 400) begin
      @(negedge clk);
      acc = ir[d];
      step();
      waited++;
    end
    iv[d] = 1'b0;
    chk(d, "push_accept", 32'(acc), 32'd1);
    if (acc) begin
      model_add(d, c, a0, a1);
      $display("push dut%0d cmd=%02h arg0=%02h arg1=%02h", d, c, a0, a1);
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while ((exp_q[d].size() != 0 || busy_s[d]) && n < 600) begin
      step();
      n++;
    end
    chk(d, "drain_done", 32'(exp_q[d].size() == 0 && !busy_s[d]), 32'd1);
  endtask

  task automatic reset_dut(input int d);
    rst_s[d] = 1'b1;
    step();
    step();
    exp_q[d].delete();
    pos[d] = 0;
    frames_done[d] = 0;
    rst_s[d] = 1'b0;
    step();
  endtask

  // Byte monitor: checks every handshake against the reference and stall stability.
  initial begin
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; frames_done[d] = 0; stall_prev[d] = 1'b0; hold_data[d] = 8'h00;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_s[d]) begin
          stall_prev[d] = 1'b0;
        end else begin
          if (stall_prev[d]) begin
            chk(d, "hold_valid", 32'(ov[d]), 32'd1);
            chk(d, "hold_data", 32'(od[d]), 32'(hold_data[d]));
          end
          if (ov[d] && ordy[d]) begin
            if (exp_q[d].size() == 0) begin
              chk(d, "unexpected_byte", 32'(exp_q[d].size()), 32'd1);
            end else begin
              e = exp_q[d].pop_front();
              chk(d, "byte", 32'(od[d]), 32'(e));
              pos[d]++;
              if (pos[d] == 5) begin
                pos[d] = 0;
                frames_done[d]++;
              end
            end
          end
          stall_prev[d] = ov[d] && !ordy[d];
          hold_data[d]  = od[d];
        end
      end
    end
  end

  initial begin
    logic [7:0]  fr [5];
    logic [17:0] trace0, exp0;
    logic [15:0] trace1, exp1;
    logic [7:0]  held_arg0;
    logic        acc;
    int          accepts;
    int          vcount;

    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0; rdy_mode[d] = 0;
      cmd_s[d] = 8'h00; a0_s[d] = 8'h00; a1_s[d] = 8'h00;
    end

    // Reset state.
    step(); step(); step();
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_tvalid", 32'(ov[d]), 32'd0);
      chk(d, "rst_tdata", 32'(od[d]), 32'h00);
      chk(d, "rst_busy", 32'(busy_s[d]), 32'd0);
    end
    chk(0, "rst_count", 32'(fc0), 32'd0);
    chk(1, "rst_count", 32'(fc1), 32'd0);
    for (int d = 0; d < 2; d++) rst_s[d] = 1'b0;
    step();
    for (int d = 0; d < 2; d++) chk(d, "tready_after_rst", 32'(ir[d]), 32'd1);

    // Single frame, latency and back-to-back bytes.
    ordy[0] = 1'b1;
    fr[0] = 8'h6E; fr[1] = 8'h01; fr[2] = 8'hA5; fr[3] = 8'h00; fr[4] = 8'h6F;
    push(0, 8'h01, 8'hA5, 8'h00);
    chk(0, "lat_edge_k", 32'(ov[0]), 32'd0);
    step();
    chk(0, "lat_edge_k1", 32'(ov[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk(0, "seq_valid", 32'(ov[0]), 32'd1);
      chk(0, "seq_data", 32'(od[0]), 32'(fr[i]));
    end
    step();
    chk(0, "post_tvalid", 32'(ov[0]), 32'd0);
    chk(0, "count_one", 32'(fc0), 32'd1);
    chk(0, "post_busy", 32'(busy_s[0]), 32'd0);

    // Toggling ready with a delimiter-valued argument.
    rdy_mode[0] = 1; ordy[0] = 1'b1;
    push(0, 8'h07, 8'h55, 8'h6E);
    wait_drain(0);
    chk(0, "count_two", 32'(fc0), 32'd2);

    // Randomized commands and backpressure.
    rdy_mode[0] = 2;
    for (int i = 0; i < 24; i++) begin
      push(0, 8'($urandom_range(0, 10)), rand_arg(), rand_arg());
      if ($urandom_range(0, 2) == 0) step();
    end
    wait_drain(0);
    chk(0, "count_random", 32'(fc0), 32'(frames_done[0]));

    // Back-to-back frames with no gap: one idle cycle between frames.
    rdy_mode[0] = 0; ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 8'($urandom_range(0, 10)), rand_arg(), rand_arg());
    chk(0, "b2b_sof_waiting", 32'(ov[0]), 32'd1);
    ordy[0] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      trace0[i] = ov[0];
      exp0[i]   = ((i % 6) != 5);
      step();
    end
    chk(0, "b2b_valid_trace", 32'(trace0), 32'(exp0));
    wait_drain(0);

    // Fill with output stalled: exactly five commands fit.
    ordy[0] = 1'b0; accepts = 0; iv[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cmd_s[0] = 8'(accepts); a0_s[0] = rand_arg(); a1_s[0] = rand_arg();
      @(negedge clk);
      acc = ir[0];
      step();
      if (acc) begin
        model_add(0, cmd_s[0], a0_s[0], a1_s[0]);
        $display("push dut0 cmd=%02h arg0=%02h arg1=%02h", cmd_s[0], a0_s[0], a1_s[0]);
        accepts++;
      end
    end
    iv[0] = 1'b0;
    chk(0, "fill_accepts", 32'(accepts), 32'd5);
    chk(0, "fill_tready", 32'(ir[0]), 32'd0);
    ordy[0] = 1'b1;
    wait_drain(0);

    // Reset while ARG0 is stalled with commands queued.
    ordy[0] = 1'b0;
    held_arg0 = rand_arg();
    push(0, 8'h03, held_arg0, 8'h11);
    push(0, 8'h04, 8'h22, 8'h33);
    push(0, 8'h05, 8'h44, 8'h55);
    ordy[0] = 1'b1;
    step();
    step();
    ordy[0] = 1'b0;
    chk(0, "arg0_stall_valid", 32'(ov[0]), 32'd1);
    chk(0, "arg0_stall_data", 32'(od[0]), 32'(held_arg0));
    rst_s[0] = 1'b1;
    step();
    chk(0, "midrst_tvalid", 32'(ov[0]), 32'd0);
    chk(0, "midrst_count", 32'(fc0), 32'd0);
    exp_q[0].delete(); pos[0] = 0; frames_done[0] = 0;
    rst_s[0] = 1'b0;
    step();
    chk(0, "midrst_tready", 32'(ir[0]), 32'd1);
    chk(0, "midrst_busy", 32'(busy_s[0]), 32'd0);
    ordy[0] = 1'b1; vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ov[0]) vcount++;
    end
    chk(0, "midrst_no_bytes", 32'(vcount), 32'd0);

    // Three-cycle gap, then the idle pop cycle, then the next SOF.
    rdy_mode[1] = 0; ordy[1] = 1'b0;
    push(1, 8'h08, rand_arg(), rand_arg());
    push(1, 8'h09, rand_arg(), rand_arg());
    step();
    chk(1, "gap_sof_waiting", 32'(ov[1]), 32'd1);
    ordy[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      trace1[i] = ov[1];
      exp1[i]   = (i < 5) || (i >= 9 && i < 14);
      step();
    end
    chk(1, "gap_valid_trace", 32'(trace1), 32'(exp1));
    wait_drain(1);

    // Four-bit frame counter wraps after 16 frames.
    reset_dut(1);
    rdy_mode[1] = 2;
    for (int i = 0; i < 16; i++) push(1, 8'($urandom_range(0, 10)), rand_arg(), rand_arg());
    wait_drain(1);
    chk(1, "count_wrap16", 32'(fc1), 32'd0);
    push(1, 8'h0A, rand_arg(), rand_arg());
    wait_drain(1);
    chk(1, "count_wrap17", 32'(fc1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
